// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box, Rcon and key-schedule sizing functions.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EXPAND = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nr);
        return 4 * (nr + 1);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word.
// Latency: combinational.
// Backpressure: none.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule, one word per clock; optional AES_KEYEXP_ZEROIZE_EN adds a zeroize input.
// Latency: key_ready rises NW-NK cycles after the start edge (40/46/52); rd_key is combinational.
// Backpressure: none; start at any time aborts and restarts the expansion.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
)
(
    input  logic                clk,
    input  logic                rst_n,
`ifdef AES_KEYEXP_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                key_ready,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);

    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(NK);
    localparam int NW = nw_of(NR);

    localparam logic [5:0] NK6      = 6'(NK);
    localparam logic [5:0] LAST_IDX = 6'(NW - 1);
    localparam logic [2:0] KPOS_MAX = 3'(NK - 1);
    localparam logic [3:0] NR4      = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [2:0]  r_kpos;
    logic [3:0]  r_rcon_idx;
    logic [31:0] r_w [NW];

    logic        w_clear;
    logic [31:0] w_prev;
    logic [31:0] w_rot;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_t;
    logic [31:0] w_new;
    logic [5:0]  w_base;

`ifdef AES_KEYEXP_ZEROIZE_EN
    assign w_clear = zeroize;
`else
    assign w_clear = 1'b0;
`endif

    assign w_prev   = r_w[r_idx - 6'd1];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    assign w_sub_in = (r_kpos == 3'd0) ? w_rot : w_prev;

    aes_sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    // r_kpos tracks i mod NK and r_rcon_idx tracks i/NK - 1, avoiding a divider.
    always_comb begin
        w_t = w_prev;
        if (r_kpos == 3'd0) begin
            w_t = w_sub_out ^ {RCON[r_rcon_idx], 24'h0};
        end else if (NK == 8 && r_kpos == 3'd4) begin
            w_t = w_sub_out;
        end
    end

    assign w_new = r_w[r_idx - NK6] ^ w_t;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_kpos     <= '0;
            r_rcon_idx <= '0;
        end else if (w_clear) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_kpos     <= '0;
            r_rcon_idx <= '0;
        end else if (start) begin
            r_state    <= ST_EXPAND;
            r_idx      <= NK6;
            r_kpos     <= '0;
            r_rcon_idx <= '0;
        end else if (r_state == ST_EXPAND) begin
            if (r_idx == LAST_IDX) begin
                r_state <= ST_DONE;
            end else begin
                r_idx <= r_idx + 6'd1;
            end
            if (r_kpos == KPOS_MAX) begin
                r_kpos     <= '0;
                r_rcon_idx <= r_rcon_idx + 4'd1;
            end else begin
                r_kpos <= r_kpos + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NW; k++) r_w[k] <= '0;
        end else if (w_clear) begin
            for (int k = 0; k < NW; k++) r_w[k] <= '0;
        end else if (start) begin
            for (int k = 0; k < NK; k++) r_w[k] <= key_in[KEY_BITS-1-32*k -: 32];
        end else if (r_state == ST_EXPAND) begin
            r_w[r_idx] <= w_new;
        end
    end

    assign busy      = (r_state == ST_EXPAND);
    assign key_ready = (r_state == ST_DONE);
    assign w_base    = {rd_round, 2'b00};

    // Stale words from an aborted run stay in the buffer but are hidden until key_ready.
    always_comb begin
        rd_key = '0;
        if (key_ready && rd_round <= NR4) begin
            rd_key = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander at KEY_BITS 128/192/256 against FIPS-197 vectors.
// Zeroize steps are included when AES_KEYEXP_ZEROIZE_EN is defined.
module tb_aes_key_expander;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         st128, st192, st256;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic         busy128, busy192, busy256;
    logic         rdy128, rdy192, rdy256;
    logic [3:0]   rr128, rr192, rr256;
    logic [127:0] rk128, rk192, rk256;
`ifdef AES_KEYEXP_ZEROIZE_EN
    logic         zeroize;
`endif

    int total = 0;
    int bad   = 0;
    int n;
    int both;

    aes_key_expander #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(st128), .key_in(key128), .busy(busy128), .key_ready(rdy128),
        .rd_round(rr128), .rd_key(rk128)
    );

    aes_key_expander #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(st192), .key_in(key192), .busy(busy192), .key_ready(rdy192),
        .rd_round(rr192), .rd_key(rk192)
    );

    aes_key_expander #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n),
`ifdef AES_KEYEXP_ZEROIZE_EN
        .zeroize(zeroize),
`endif
        .start(st256), .key_in(key256), .busy(busy256), .key_ready(rdy256),
        .rd_round(rr256), .rd_key(rk256)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int sel);
        case (sel)
            0:       st128 = 1'b1;
            1:       st192 = 1'b1;
            default: st256 = 1'b1;
        endcase
        tick();
        st128 = 1'b0;
        st192 = 1'b0;
        st256 = 1'b0;
    endtask

    // Counts edges after the start edge until key_ready, bounded at 200.
    task automatic wait_ready(input int sel, output int cnt, output int overlap);
        logic r;
        r       = 1'b0;
        cnt     = 0;
        overlap = 0;
        while (!r && cnt < 200) begin
            tick();
            cnt++;
            case (sel)
                0:       begin r = rdy128; if (rdy128 && busy128) overlap++; end
                1:       begin r = rdy192; if (rdy192 && busy192) overlap++; end
                default: begin r = rdy256; if (rdy256 && busy256) overlap++; end
            endcase
        end
    endtask

    initial begin
        st128 = 1'b0; st192 = 1'b0; st256 = 1'b0;
        key128 = '0; key192 = '0; key256 = '0;
        rr128 = '0; rr192 = '0; rr256 = '0;
`ifdef AES_KEYEXP_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk1("rst_busy", busy128, 1'b0);
        chk1("rst_ready", rdy128, 1'b0);
        chk("rst_rdkey0", rk128, 128'h0);
        rr128 = 4'd5;
        #1;
        chk("rst_rdkey5", rk128, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // AES-192
        key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        pulse_start(1);
        chk1("k192_busy_after_start", busy192, 1'b1);
        chk1("k192_ready_after_start", rdy192, 1'b0);
        wait_ready(1, n, both);
        chki("k192_latency", n, 46);
        chki("k192_busy_ready_overlap", both, 0);
        chk1("k192_busy_done", busy192, 1'b0);
        rr192 = 4'd12;
        #1;
        chk("k192_round12", rk192, 128'he98ba06f448c773c8ecc720401002202);
        rr192 = 4'd0;
        #1;
        chk("k192_round0", rk192, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rr192 = 4'd13;
        #1;
        chk("k192_round13_oob", rk192, 128'h0);

        // AES-256
        key256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        pulse_start(2);
        chk1("k256_busy_after_start", busy256, 1'b1);
        wait_ready(2, n, both);
        chki("k256_latency", n, 52);
        chki("k256_busy_ready_overlap", both, 0);
        rr256 = 4'd14;
        #1;
        chk("k256_round14", rk256, 128'hfe4890d1e6188d0b046df344706c631e);
        rr256 = 4'd15;
        #1;
        chk("k256_round15_oob", rk256, 128'h0);

        // AES-128
        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pulse_start(0);
        chk1("k128_busy_after_start", busy128, 1'b1);
        rr128 = 4'd1;
        #1;
        chk("k128_rdkey_while_busy", rk128, 128'h0);
        wait_ready(0, n, both);
        chki("k128_latency", n, 40);
        chki("k128_busy_ready_overlap", both, 0);
        rr128 = 4'd1;
        #1;
        chk("k128_round1", rk128, 128'ha0fafe1788542cb123a339392a6c7605);
        rr128 = 4'd10;
        #1;
        chk("k128_round10", rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rr128 = 4'd0;
        #1;
        chk("k128_round0", rk128, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rr128 = 4'd13;
        #1;
        chk("k128_round13_oob", rk128, 128'h0);

        // Restart from DONE, then abort mid-expansion with an all-zero key
        pulse_start(0);
        chk1("restart_ready_drops", rdy128, 1'b0);
        chk1("restart_busy", busy128, 1'b1);
        repeat (9) tick();
        key128 = 128'h0;
        pulse_start(0);
        chk1("abort_ready_low", rdy128, 1'b0);
        wait_ready(0, n, both);
        chki("abort_latency", n, 40);
        chki("abort_busy_ready_overlap", both, 0);
        rr128 = 4'd10;
        #1;
        chk("zero_key_round10", rk128, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Asynchronous reset mid-expansion
        key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pulse_start(0);
        repeat (15) tick();
        rst_n = 1'b0;
        #2;
        chk1("midrst_busy", busy128, 1'b0);
        chk1("midrst_ready", rdy128, 1'b0);
        for (int r = 0; r < 16; r++) begin
            rr128 = 4'(r);
            #1;
            chk($sformatf("midrst_rdkey%0d", r), rk128, 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk1("post_rst_busy", busy128, 1'b0);

`ifdef AES_KEYEXP_ZEROIZE_EN
        pulse_start(0);
        wait_ready(0, n, both);
        chki("zz_pre_latency", n, 40);
        zeroize = 1'b1;
        st128 = 1'b1;
        tick();
        zeroize = 1'b0;
        st128 = 1'b0;
        chk1("zz_ready", rdy128, 1'b0);
        chk1("zz_busy", busy128, 1'b0);
        rr128 = 4'd1;
        #1;
        chk("zz_rdkey1", rk128, 128'h0);
        repeat (3) tick();
        chk1("zz_no_expand", busy128, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
